// File: rtl/ram_byte_bridge.sv
// ram_byte_bridge
//   Serves a 32-bit CPU data-port request by walking the four byte lanes of
//   an 8-bit synchronous external RAM, one byte per clock, while holding the
//   CPU with stall_o.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous, active-low reset
//   ce_i             request valid (held by the CPU while stall_o=1)
//   we_i             1 = write, 0 = read
//   addr_i[31:0]     byte address; [1:0] ignored, bits above ADDR_W-1 ignored
//   byte_selected_i  lane enables, bit i covers data bits [8i+7:8i]
//   data_i[31:0]     write data
//   data_o[31:0]     read data, updated in the DONE cycle of a read only
//   stall_o          CPU must hold its request
//   mem_addr_o       external byte address
//   mem_dout_o       external write byte
//   mem_wr_o         external write strobe
//   mem_din_i        external read byte, one cycle behind mem_addr_o
module ram_byte_bridge #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        byte_selected_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  localparam int WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        idx_reg, idx_next;
  logic [WA_W-1:0]   word_addr_reg, word_addr_next;
  logic              we_reg, we_next;
  logic [3:0]        sel_reg, sel_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [7:0]        mem_dout_next;
  logic              mem_wr_next;

  // Lanes 0..2 of a read are collected here so data_o changes only once,
  // when lane 3 arrives at the end of the idx=4 cycle.
  logic [23:0]       rd_buf_reg;
  logic              rd_cap;
  logic [1:0]        cap_lane;
  logic [7:0]        cap_byte;

  // Gated by rst so the CPU is never stalled while the bridge is in reset.
  assign stall_o = rst & ce_i & (state_reg != DONE);

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    word_addr_next = word_addr_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    wdata_next     = wdata_reg;
    mem_addr_next  = mem_addr_o;
    mem_dout_next  = mem_dout_o;
    mem_wr_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ce_i) begin
          word_addr_next = addr_i[ADDR_W-1:2];
          we_next        = we_i;
          sel_next       = byte_selected_i;
          wdata_next     = data_i;
          state_next     = ACCESS;
          idx_next       = 3'd0;
          // Outputs for lane 0 are registered here so they appear in the
          // first ACCESS cycle.
          mem_addr_next  = {addr_i[ADDR_W-1:2], 2'b00};
          mem_dout_next  = data_i[7:0];
          mem_wr_next    = we_i & byte_selected_i[0];
        end
      end
      ACCESS: begin
        // A read needs one extra cycle (idx=4) to collect the last byte.
        if ((we_reg && idx_reg == 3'd3) || idx_reg == 3'd4) begin
          state_next = DONE;
          idx_next   = 3'd0;
        end else begin
          idx_next      = idx_reg + 3'd1;
          mem_addr_next = {word_addr_reg, idx_next[1:0]};
          mem_dout_next = wdata_reg[{idx_next[1:0], 3'b000} +: 8];
          mem_wr_next   = we_reg & sel_reg[idx_next[1:0]];
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      word_addr_reg <= '0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'd0;
      wdata_reg     <= 32'd0;
      mem_addr_o    <= '0;
      mem_dout_o    <= 8'd0;
      mem_wr_o      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      word_addr_reg <= word_addr_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      wdata_reg     <= wdata_next;
      mem_addr_o    <= mem_addr_next;
      mem_dout_o    <= mem_dout_next;
      mem_wr_o      <= mem_wr_next;
    end
  end

  // mem_din_i in an ACCESS cycle with idx>=1 answers the address of lane idx-1.
  assign rd_cap   = (state_reg == ACCESS) && !we_reg && (idx_reg != 3'd0);
  assign cap_lane = 2'(idx_reg - 3'd1);
  assign cap_byte = sel_reg[cap_lane] ? mem_din_i : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_buf_reg <= 24'd0;
      data_o     <= 32'd0;
    end else if (rd_cap) begin
      case (idx_reg)
        3'd1:    rd_buf_reg[7:0]   <= cap_byte;
        3'd2:    rd_buf_reg[15:8]  <= cap_byte;
        3'd3:    rd_buf_reg[23:16] <= cap_byte;
        default: data_o            <= {cap_byte, rd_buf_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_ram_byte_bridge.sv
// Directed bench for ram_byte_bridge. A per-transaction model computes the
// expected cycle-by-cycle behaviour from latency and lane rules; a single
// compare process checks it at every falling edge. Literal checks pin the
// model on the documented examples.
module tb_ram_byte_bridge;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce_i, we_i;
  logic [31:0]       addr_i, data_i;
  logic [3:0]        byte_selected_i;
  logic [31:0]       data_o;
  logic              stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic [7:0]        mem_din_i;

  ram_byte_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .byte_selected_i(byte_selected_i), .data_i(data_i), .data_o(data_o),
    .stall_o(stall_o), .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o),
    .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  // External byte RAM: registered read, write on strobe.
  logic [7:0] ext_mem [0:(1<<ADDR_W)-1];
  logic [7:0] shadow  [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    mem_din_i <= ext_mem[mem_addr_o];
    if (mem_wr_o) ext_mem[mem_addr_o] = mem_dout_o;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    string             nm;
    bit                c_stall; logic s;
    bit                c_wr;    logic w;
    bit                c_addr;  logic [ADDR_W-1:0] a;
    bit                c_dout;  logic [7:0] d;
    bit                c_data;  logic [31:0] q;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_data = 32'd0;

  function automatic exp_t blank(string nm);
    exp_t e;
    e.nm = nm;
    e.c_stall = 1'b0; e.s = 1'b0; e.c_wr = 1'b0; e.w = 1'b0;
    e.c_addr = 1'b0; e.a = '0; e.c_dout = 1'b0; e.d = 8'd0;
    e.c_data = 1'b0; e.q = 32'd0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.c_stall) chk({e.nm, ".stall"}, 32'(stall_o), 32'(e.s));
      if (e.c_wr)    chk({e.nm, ".wr"},    32'(mem_wr_o), 32'(e.w));
      if (e.c_addr)  chk({e.nm, ".addr"},  32'(mem_addr_o), 32'(e.a));
      if (e.c_dout)  chk({e.nm, ".dout"},  32'(mem_dout_o), 32'(e.d));
      if (e.c_data)  chk({e.nm, ".data"},  data_o, e.q);
    end
  end

  // One CPU request. Cycle n=0 is the request cycle T; DONE is n=len.
  task automatic txn(string nm, bit we, logic [31:0] addr, logic [3:0] sel,
                     logic [31:0] data, bit scramble);
    int                len;
    logic [ADDR_W-1:0] base;
    logic [31:0]       rword;
    exp_t              e;
    len  = we ? 5 : 6;
    base = addr[ADDR_W-1:0] & ~(ADDR_W'(3));
    rword = 32'd0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) rword[8*i +: 8] = shadow[base + ADDR_W'(i)];
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = we; addr_i = addr; byte_selected_i = sel; data_i = data;
    for (int n = 0; n <= len; n++) begin
      e = blank(nm);
      e.c_stall = 1'b1; e.s = (n < len);
      e.c_wr = 1'b1; e.w = 1'b0;
      if (n >= 1 && n <= 4) begin
        e.c_addr = 1'b1; e.a = base + ADDR_W'(n - 1);
        if (we) begin
          e.w = sel[n-1];
          e.c_dout = 1'b1; e.d = data[8*(n-1) +: 8];
        end
      end
      if (we || n == 0) begin e.c_data = 1'b1; e.q = model_data; end
      if (!we && n == len) begin e.c_data = 1'b1; e.q = rword; end
      exp_q.push_back(e);
    end
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (sel[i]) shadow[base + ADDR_W'(i)] = data[8*i +: 8];
    end else begin
      model_data = rword;
    end
    for (int n = 1; n <= len; n++) begin
      @(posedge clk); #1;
      if (scramble && n < len) begin
        we_i = ~we; addr_i = ~addr; data_i = ~data; byte_selected_i = ~sel;
      end
    end
    $display("txn %s we=%0d addr=%h sel=%b data=%h -> data_o=%h", nm, we, addr, sel, data, data_o);
  endtask

  task automatic idle(string nm);
    exp_t e;
    @(posedge clk); #1;
    ce_i = 1'b0; we_i = 1'b1; byte_selected_i = 4'hF;
    e = blank(nm);
    e.c_stall = 1'b1; e.s = 1'b0;
    e.c_wr = 1'b1; e.w = 1'b0;
    e.c_data = 1'b1; e.q = model_data;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic preload(logic [ADDR_W-1:0] a, logic [7:0] v);
    ext_mem[a] = v;
    shadow[a]  = v;
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0;
    byte_selected_i = 4'hF; data_i = 32'hFFFF_FFFF;
    preload(17'h300, 8'h01); preload(17'h301, 8'h02);
    preload(17'h302, 8'h03); preload(17'h303, 8'h04);
    for (int i = 0; i < 4; i++) preload(17'h204 + 17'(i), 8'h5A);
    preload(17'h402, 8'h77);

    // Asynchronous reset entry with a request pending.
    #1 rst = 1'b0;
    #2;
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.wr", 32'(mem_wr_o), 32'd0);
    chk("reset.data", data_o, 32'd0);
    chk("reset.addr", 32'(mem_addr_o), 32'd0);
    chk("reset.dout", 32'(mem_dout_o), 32'd0);
    @(posedge clk); #1;
    ce_i = 1'b0; rst = 1'b1;
    $display("reset released");

    idle("idle0");
    idle("idle1");

    txn("wr_full", 1'b1, 32'h0000_0100, 4'hF, 32'hAABB_CCDD, 1'b1);
    chk("wr_full.m100", 32'(ext_mem[17'h100]), 32'hDD);
    chk("wr_full.m101", 32'(ext_mem[17'h101]), 32'hCC);
    chk("wr_full.m102", 32'(ext_mem[17'h102]), 32'hBB);
    chk("wr_full.m103", 32'(ext_mem[17'h103]), 32'hAA);
    idle("idle2");

    txn("wr_part", 1'b1, 32'h0000_0204, 4'b0100, 32'h1122_3344, 1'b0);
    chk("wr_part.m206", 32'(ext_mem[17'h206]), 32'h22);
    chk("wr_part.m204", 32'(ext_mem[17'h204]), 32'h5A);
    chk("wr_part.m207", 32'(ext_mem[17'h207]), 32'h5A);
    idle("idle3");

    txn("rd_nosel", 1'b0, 32'h0000_0300, 4'b0000, 32'h0, 1'b0);
    chk("rd_nosel.lit", data_o, 32'h0000_0000);
    idle("idle4");

    txn("rd_full", 1'b0, 32'hFFFE_0303, 4'hF, 32'h0, 1'b1);
    chk("rd_full.lit", data_o, 32'h0403_0201);
    idle("idle5");

    txn("rd_byte", 1'b0, 32'h0000_0300, 4'b0010, 32'h0, 1'b0);
    chk("rd_byte.lit", data_o, 32'h0000_0200);
    idle("idle6");

    txn("rd_full2", 1'b0, 32'h0000_0300, 4'hF, 32'h0, 1'b0);
    // Back-to-back with ce_i high throughout.
    txn("b2b_wr", 1'b1, 32'h0000_0400, 4'b1011, 32'hCAFE_F00D, 1'b0);
    chk("b2b_wr.hold", data_o, 32'h0403_0201);
    txn("b2b_rd", 1'b0, 32'h0000_0400, 4'hF, 32'h0, 1'b0);
    chk("b2b_rd.lit", data_o, 32'hCA77_F00D);
    idle("idle7");
    drain();

    // Reset in the middle of a write while the strobe is high.
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0500;
    byte_selected_i = 4'hF; data_i = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst.pre_wr", 32'(mem_wr_o), 32'd1);
    chk("midrst.pre_stall", 32'(stall_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst.wr", 32'(mem_wr_o), 32'd0);
    chk("midrst.data", data_o, 32'd0);
    chk("midrst.stall", 32'(stall_o), 32'd0);
    model_data = 32'd0;
    @(posedge clk); #1;
    chk("midrst.held_wr", 32'(mem_wr_o), 32'd0);
    ce_i = 1'b0; rst = 1'b1;
    $display("mid-access reset released");
    idle("idle8");
    idle("idle9");

    txn("post_wr", 1'b1, 32'h0000_0600, 4'hF, 32'h8765_4321, 1'b0);
    idle("idle10");
    txn("post_rd", 1'b0, 32'h0000_0600, 4'b1001, 32'h0, 1'b0);
    chk("post_rd.lit", data_o, 32'h8700_0021);
    idle("idle11");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
